// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: opcodes, field positions,
// controller state encoding and the operation codes understood by the ALU.
package alu_pkg;

  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_AND  = 4'h2;
  localparam logic [3:0] OPC_OR   = 4'h3;
  localparam logic [3:0] OPC_ALU4 = 4'h4;
  localparam logic [3:0] OPC_ALU5 = 4'h5;
  localparam logic [3:0] OPC_ALU6 = 4'h6;
  localparam logic [3:0] OPC_ALU7 = 4'h7;
  localparam logic [3:0] OPC_LLI  = 4'h8;
  localparam logic [3:0] OPC_LUI  = 4'h9;
  localparam logic [3:0] OPC_HALT = 4'hE;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;
  localparam int K8_HI  = 7;
  localparam int K8_LO  = 0;

  // Bit of the ALU op that selects the immediate form (B forced to zero).
  localparam int ALU_IMM_BIT = 2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_OP4 = 3'd4;
  localparam logic [2:0] ALU_OP5 = 3'd5;
  localparam logic [2:0] ALU_OP6 = 3'd6;
  localparam logic [2:0] ALU_OP7 = 3'd7;

  typedef enum logic { ST_RUN = 1'b0, ST_HALT = 1'b1 } state_t;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_ALU  = 2'd1,
    K_LLI  = 2'd2,
    K_LUI  = 2'd3
  } kind_t;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU operand/result and writeback bus of the issue stage.
interface alu_issue_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [DW-1:0] alu_A;
  logic [DW-1:0] alu_B;
  logic [2:0]    alu_op;
  logic [3:0]    alu_imm;
  logic [DW-1:0] alu_out;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  modport master (
    output instr_valid, instr, alu_out,
    input  instr_ready, alu_A, alu_B, alu_op, alu_imm, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  instr_valid, instr, alu_out,
    output instr_ready, alu_A, alu_B, alu_op, alu_imm, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hard-wired to zero, whole array cleared by reset.
module regfile_2r1w #(
  parameter int  NREG = 16,
  parameter int  DW   = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage around the combinational ALU: decode, bypassed operand
// read, one-cycle ALU drive, register writeback and a RUN/HALT controller.
module alu_issue
  import alu_pkg::*;
#(
  parameter int  NREG = 16,
  parameter int  DW   = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus,
  input  logic        resume,
  output logic        halted
);

  function automatic logic signed [DW-1:0] sext8(input logic signed [7:0] k);
    return DW'(k);
  endfunction

  function automatic logic [DW-1:0] lui_merge(input logic [7:0] k, input logic [DW-1:0] cur);
    return DW'({k, cur[7:0]});
  endfunction

  state_t        state_q, state_d;
  kind_t         kind_d;
  logic          accept;
  logic [3:0]    opc;
  logic [AW-1:0] rd, rs1, rs2, ra1;
  logic [7:0]    k8;
  logic [DW-1:0] rd1, rd2, op_a, op_b, imm_res;

  logic          ex_valid;
  logic [AW-1:0] ex_rd;
  kind_t         ex_kind;
  logic [DW-1:0] ex_imm_res;
  logic          wb_en;
  logic [DW-1:0] wb_val;

  logic [DW-1:0] alu_a_q, alu_b_q, wb_data_q;
  logic [2:0]    alu_op_q;
  logic [3:0]    alu_imm_q;
  logic          wb_valid_q;
  logic [AW-1:0] wb_addr_q;

  assign opc = bus.instr[OPC_HI:OPC_LO];
  assign rd  = bus.instr[RD_HI:RD_LO];
  assign rs1 = bus.instr[RS1_HI:RS1_LO];
  assign rs2 = bus.instr[RS2_HI:RS2_LO];
  assign k8  = bus.instr[K8_HI:K8_LO];

  assign bus.instr_ready = (state_q == ST_RUN);
  assign accept          = bus.instr_valid && bus.instr_ready;
  assign halted          = (state_q == ST_HALT);

  always_comb begin
    kind_d = K_NONE;
    if (!opc[3])            kind_d = K_ALU;
    else if (opc == OPC_LLI) kind_d = K_LLI;
    else if (opc == OPC_LUI) kind_d = K_LUI;
  end

  // LUI reuses read port 1 to fetch the destination's current low byte.
  assign ra1 = (opc == OPC_LUI) ? rd : rs1;

  regfile_2r1w #(.NREG(NREG), .DW(DW)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ra1),
    .ra2   (rs2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (wb_en),
    .wa    (ex_rd),
    .wd    (wb_val)
  );

  assign wb_en  = ex_valid && (ex_rd != '0);
  assign wb_val = (ex_kind == K_ALU) ? bus.alu_out : ex_imm_res;

  // wb_en already excludes R0, so a match implies a non-zero source register.
  assign op_a    = (wb_en && (ra1 == ex_rd)) ? wb_val : rd1;
  assign op_b    = (wb_en && (rs2 == ex_rd)) ? wb_val : rd2;
  assign imm_res = (kind_d == K_LUI) ? lui_merge(k8, op_a) : sext8(k8);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (accept && (opc == OPC_HALT)) state_d = ST_HALT;
      ST_HALT: if (resume)                      state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Issue boundary: operands into the ALU registers, result kind into ex_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_kind    <= K_NONE;
      ex_imm_res <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      alu_imm_q  <= '0;
    end else begin
      ex_valid <= accept && (kind_d != K_NONE);
      if (accept) begin
        alu_a_q    <= op_a;
        alu_b_q    <= (kind_d == K_ALU && !opc[ALU_IMM_BIT]) ? op_b : '0;
        alu_op_q   <= opc[2:0];
        alu_imm_q  <= bus.instr[RS2_HI:RS2_LO];
        ex_rd      <= rd;
        ex_kind    <= kind_d;
        ex_imm_res <= imm_res;
      end
    end
  end

  // Writeback boundary: report the write committed at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_en;
      if (wb_en) begin
        wb_addr_q <= ex_rd;
        wb_data_q <= wb_val;
      end
    end
  end

  assign bus.alu_A    = alu_a_q;
  assign bus.alu_B    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.alu_imm  = alu_imm_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: stands in for the ALU, drives instruction vectors and
// checks ALU operands and writebacks against a register model and scoreboard.
module tb_alu_issue;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_t;

  typedef struct {
    logic [15:0] instr;
    bit          chk;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [3:0]  imm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic resume = 1'b0;
  logic halted;

  alu_issue_if #(.DW(16), .AW(4)) bus ();

  alu_issue #(.NREG(16), .DW(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .resume (resume),
    .halted (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_m(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op, input logic [3:0] imm);
    logic [31:0] t;
    t = {a, a} << imm;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a << imm;
      3'd5:    return a >> imm;
      3'd6:    return $signed(a) >>> imm;
      default: return t[31:16];
    endcase
  endfunction

  always_comb bus.alu_out = alu_m(bus.alu_A, bus.alu_B, bus.alu_op, bus.alu_imm);

  int          total = 0;
  int          bad = 0;
  int          wb_cnt = 0;
  logic [15:0] rm [16];
  bit          m_halted = 1'b0;
  wb_t         sb [$];
  vec_t        vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_wb();
    wb_t e;
    if (bus.wb_valid === 1'b1) begin
      wb_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, want no write", bus.wb_addr, bus.wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
        chk("wb_data", 32'(bus.wb_data), 32'(e.data));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_wb();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rm[i] = 16'h0000;
    sb.delete();
    m_halted = 1'b0;
  endtask

  task automatic model_issue(input logic [15:0] w);
    logic [3:0]  opc, rd, rs1, rs2;
    logic [7:0]  k8;
    logic [15:0] res, b;
    bit          wr;
    opc = w[15:12]; rd = w[11:8]; rs1 = w[7:4]; rs2 = w[3:0]; k8 = w[7:0];
    wr = 1'b0;
    res = 16'h0000;
    if (!opc[3]) begin
      b = opc[2] ? 16'h0000 : rm[rs2];
      res = alu_m(rm[rs1], b, opc[2:0], rs2);
      wr = 1'b1;
    end else if (opc == 4'h8) begin
      res = {{8{k8[7]}}, k8};
      wr = 1'b1;
    end else if (opc == 4'h9) begin
      res = {k8, rm[rd][7:0]};
      wr = 1'b1;
    end else if (opc == 4'hE) begin
      m_halted = 1'b1;
    end
    if (wr && rd != 4'h0) begin
      rm[rd] = res;
      sb.push_back('{addr: rd, data: res});
    end
  endtask

  task automatic send(input logic [15:0] w);
    bus.instr_valid = 1'b1;
    bus.instr = w;
    if (!m_halted) model_issue(w);
    tick();
  endtask

  task automatic drain();
    repeat (6) tick();
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0;
    logic [15:0] w;
    vt[0]  = '{16'h81F9, 1'b0, 16'h0000, 16'h0000, 3'd0, 4'd0};
    vt[1]  = '{16'h8207, 1'b0, 16'h0000, 16'h0000, 3'd0, 4'd0};
    vt[2]  = '{16'h0312, 1'b1, 16'hFFF9, 16'h0007, 3'd0, 4'd2};
    vt[3]  = '{16'h8454, 1'b0, 16'h0000, 16'h0000, 3'd0, 4'd0};
    vt[4]  = '{16'h9480, 1'b0, 16'h0000, 16'h0000, 3'd0, 4'd0};
    vt[5]  = '{16'h654F, 1'b1, 16'h8054, 16'h0000, 3'd6, 4'd15};
    vt[6]  = '{16'h8012, 1'b0, 16'h0000, 16'h0000, 3'd0, 4'd0};
    vt[7]  = '{16'h0600, 1'b1, 16'h0000, 16'h0000, 3'd0, 4'd0};
    vt[8]  = '{16'h1731, 1'b1, 16'h0000, 16'hFFF9, 3'd1, 4'd1};
    vt[9]  = '{16'hA000, 1'b0, 16'h0000, 16'h0000, 3'd0, 4'd0};
    vt[10] = '{16'h2841, 1'b1, 16'h8054, 16'hFFF9, 3'd2, 4'd1};
    vt[11] = '{16'h4913, 1'b1, 16'hFFF9, 16'h0000, 3'd4, 4'd3};

    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_alu_A", 32'(bus.alu_A), 0);
    chk("rst_wb_data", 32'(bus.wb_data), 0);
    chk("rst_alu_op", 32'(bus.alu_op), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_instr_ready", 32'(bus.instr_ready), 1);

    for (int i = 0; i < 12; i++) begin
      send(vt[i].instr);
      if (vt[i].chk) begin
        chk($sformatf("v%0d_alu_A", i), 32'(bus.alu_A), 32'(vt[i].a));
        chk($sformatf("v%0d_alu_B", i), 32'(bus.alu_B), 32'(vt[i].b));
        chk($sformatf("v%0d_alu_op", i), 32'(bus.alu_op), 32'(vt[i].op));
        chk($sformatf("v%0d_alu_imm", i), 32'(bus.alu_imm), 32'(vt[i].imm));
      end
    end
    bus.instr_valid = 1'b0;
    drain();

    // HALT with an older write still in flight and the next instruction held.
    send(16'h8B5A);
    send(16'hE000);
    chk("halt_ready", 32'(bus.instr_ready), 0);
    chk("halt_halted", 32'(halted), 1);
    bus.instr = 16'h8A33;
    repeat (3) begin
      tick();
      chk("halt_hold_ready", 32'(bus.instr_ready), 0);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    m_halted = 1'b0;
    chk("resume_ready", 32'(bus.instr_ready), 1);
    chk("resume_halted", 32'(halted), 0);
    model_issue(16'h8A33);
    tick();
    bus.instr_valid = 1'b0;
    drain();

    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_in_run_halted", 32'(halted), 0);
    chk("resume_in_run_ready", 32'(bus.instr_ready), 1);

    // Reset the cycle after issuing ADD r7: its writeback must vanish.
    send(16'h0712);
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    w0 = wb_cnt;
    #1;
    chk("midrst_wb_valid", 32'(bus.wb_valid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_no_wb", 32'(wb_cnt), 32'(w0));
    chk("midrst_ready", 32'(bus.instr_ready), 1);
    chk("midrst_halted", 32'(halted), 0);

    for (int i = 1; i < 16; i++) begin
      w = {4'h3, 4'h0, 4'(i), 4'h0};
      send(w);
      chk($sformatf("midrst_R%0d", i), 32'(bus.alu_A), 0);
    end
    bus.instr_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
